// File: rtl/falling_object_pool_fsm_if.sv
// Purpose: bundles the level-controller and per-object signals of the falling object pool.
// Latency: none; this file only groups wires.
// Backpressure: none; every signal is a level or a single-cycle pulse.
//
// Ports (all signals are plain nets):
//   startOfLevel, endLevel, enable, tick : level-controller controls
//   exceed      [NUM_OBJ]                : per-slot "object left the screen" pulse
//   objectSpeed [SPEED_BITS]             : current level speed
//   visible, loadX [NUM_OBJ]             : per-slot state decodes
//   topLeftX [NUM_OBJ*X_BITS]            : signed launch X per slot
//   speed    [NUM_OBJ*SPEED_BITS]        : per-slot speed (0 unless moving)
//   activeCount [4]                      : slots currently moving
// The master modport is the level-controller / drawing side; slave is the pool itself.
interface falling_object_pool_fsm_if #(
  parameter int NUM_OBJ    = 4,
  parameter int X_BITS     = 11,
  parameter int SPEED_BITS = 8
);
  logic                         startOfLevel;
  logic                         endLevel;
  logic                         enable;
  logic                         tick;
  logic [NUM_OBJ-1:0]           exceed;
  logic [SPEED_BITS-1:0]        objectSpeed;
  logic [NUM_OBJ-1:0]           visible;
  logic [NUM_OBJ-1:0]           loadX;
  logic [NUM_OBJ*X_BITS-1:0]    topLeftX;
  logic [NUM_OBJ*SPEED_BITS-1:0] speed;
  logic [3:0]                   activeCount;

  modport master (
    output startOfLevel, endLevel, enable, tick, exceed, objectSpeed,
    input  visible, loadX, topLeftX, speed, activeCount
  );

  modport slave (
    input  startOfLevel, endLevel, enable, tick, exceed, objectSpeed,
    output visible, loadX, topLeftX, speed, activeCount
  );
endinterface

// File: rtl/falling_object_pool_fsm.sv
// Purpose: spawns and tracks NUM_OBJ falling objects; each slot waits a random number of
//          ticks, then launches at a random X while a shared arbiter caps on-screen slots.
// Latency: a granted slot is visible the cycle after its grant; outputs decode registered state.
// Backpressure: none; ARMED slots simply wait for a free place (at most one launch per cycle).
//
// Ports:
//   clk     : system clock
//   resetN  : asynchronous active-low reset (all slots IDLE, counters/X cleared, LFSR = SEED)
//   bus     : falling_object_pool_fsm_if.slave (controls in, per-slot decodes out)
module falling_object_pool_fsm #(
  parameter int          NUM_OBJ    = 4,
  parameter int          X_BITS     = 11,
  parameter int          SPEED_BITS = 8,
  parameter int          MIN_X      = 32,
  parameter int          MAX_X      = 576,
  parameter int          CNT_BITS   = 8,
  parameter int          MIN_WAIT   = 50,
  parameter int          MAX_WAIT   = 150,
  parameter int          MAX_ACTIVE = 2,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input logic                       clk,
  input logic                       resetN,
  falling_object_pool_fsm_if.slave  bus
);

  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam int          WAIT_SPAN = MAX_WAIT - MIN_WAIT + 1;
  localparam int          X_SPAN    = MAX_X - MIN_X + 1;
  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ARMED  = 2'd2,
    MOVING = 2'd3
  } slotState_t;

  logic [15:0]           lfsr;
  slotState_t            state     [NUM_OBJ];
  slotState_t            stateNext [NUM_OBJ];
  logic [CNT_BITS-1:0]   cnt       [NUM_OBJ];
  logic [CNT_BITS-1:0]   cntNext   [NUM_OBJ];
  logic [X_BITS-1:0]     posX      [NUM_OBJ];
  logic [X_BITS-1:0]     posXNext  [NUM_OBJ];
  logic [CNT_BITS-1:0]   randDelay [NUM_OBJ];
  logic [X_BITS-1:0]     randX     [NUM_OBJ];
  logic [NUM_OBJ-1:0]    grant;
  logic [3:0]            activeCnt;
  logic                  canLaunch;
  logic                  granted;

  logic [NUM_OBJ-1:0]            visibleVec;
  logic [NUM_OBJ-1:0]            loadXVec;
  logic [NUM_OBJ*X_BITS-1:0]     topLeftXVec;
  logic [NUM_OBJ*SPEED_BITS-1:0] speedVec;

  // Per-slot random values: one shared LFSR, decorrelated by a per-slot XOR constant.
  for (genvar g = 0; g < NUM_OBJ; g++) begin : gSlotRand
    localparam logic [15:0] SLOT_MIX = 16'(32'(g) * 32'h0000_9E37);
    logic [15:0] rVal;
    assign rVal         = lfsr ^ SLOT_MIX;
    assign randDelay[g] = CNT_BITS'(32'(MIN_WAIT) + (32'(rVal) % 32'(WAIT_SPAN)));
    assign randX[g]     = X_BITS'(32'(MIN_X) + (32'(rVal) % 32'(X_SPAN)));
  end

  // Count from registered state: a slot leaving MOVING still occupies its place this
  // cycle, so a waiting slot can only take the freed place on the following cycle.
  always_comb begin
    activeCnt = 4'd0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (state[i] == MOVING) begin
        activeCnt = activeCnt + 4'd1;
      end
    end
  end

  assign canLaunch = bus.enable && (int'(activeCnt) < MAX_ACTIVE);

  // Fixed-priority arbiter: only the lowest-index ARMED slot may launch in a cycle.
  always_comb begin
    grant   = '0;
    granted = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (!granted && canLaunch && (state[i] == ARMED)) begin
        grant[i] = 1'b1;
        granted  = 1'b1;
      end
    end
  end

  // Per-slot next state. endLevel overrides everything; a countdown load always beats a
  // tick in the same cycle because the load paths never look at tick.
  always_comb begin
    for (int i = 0; i < NUM_OBJ; i++) begin
      stateNext[i] = state[i];
      cntNext[i]   = cnt[i];
      posXNext[i]  = posX[i];
      if (bus.endLevel) begin
        stateNext[i] = IDLE;
        cntNext[i]   = '0;
      end else begin
        unique case (state[i])
          IDLE: begin
            if (bus.startOfLevel) begin
              stateNext[i] = WAIT;
              cntNext[i]   = randDelay[i];
            end
          end
          WAIT: begin
            if (bus.enable && bus.tick) begin
              if (cnt[i] <= CNT_BITS'(1)) begin
                stateNext[i] = ARMED;
                cntNext[i]   = '0;
              end else begin
                cntNext[i] = cnt[i] - CNT_BITS'(1);
              end
            end
          end
          ARMED: begin
            if (grant[i]) begin
              stateNext[i] = MOVING;
              posXNext[i]  = randX[i];
            end
          end
          MOVING: begin
            // Pausing the game pulls every moving object back into a fresh wait.
            if (bus.exceed[i] || !bus.enable) begin
              stateNext[i] = WAIT;
              cntNext[i]   = randDelay[i];
            end
          end
          default: begin
            stateNext[i] = IDLE;
            cntNext[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lfsr <= SEED_EFF;
      for (int i = 0; i < NUM_OBJ; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
        posX[i]  <= '0;
      end
    end else begin
      // The LFSR free-runs so that pausing does not freeze the random sequence.
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
      for (int i = 0; i < NUM_OBJ; i++) begin
        state[i] <= stateNext[i];
        cnt[i]   <= cntNext[i];
        posX[i]  <= posXNext[i];
      end
    end
  end

  // Output decode; speed tracks objectSpeed combinationally while moving.
  always_comb begin
    visibleVec  = '0;
    loadXVec    = '0;
    topLeftXVec = '0;
    speedVec    = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      visibleVec[i]                       = (state[i] == MOVING);
      loadXVec[i]                         = (state[i] == WAIT) || (state[i] == ARMED);
      topLeftXVec[i*X_BITS +: X_BITS]     = posX[i];
      speedVec[i*SPEED_BITS +: SPEED_BITS] = (state[i] == MOVING) ? bus.objectSpeed : '0;
    end
  end

  assign bus.visible     = visibleVec;
  assign bus.loadX       = loadXVec;
  assign bus.topLeftX    = topLeftXVec;
  assign bus.speed       = speedVec;
  assign bus.activeCount = activeCnt;

endmodule

// File: doc/falling_object_pool_fsm.md
Name: falling_object_pool_fsm

Overview:
- Multi-slot spawner/controller for falling game objects (viruses, pickups). One instance manages NUM_OBJ independent object slots.
- Each slot idles until a level starts, waits a random number of tenth-second ticks, then launches at a random X with the level speed.
- A shared arbiter caps how many slots are on screen at once.
- Sits between the level controller (start/end/enable, tick) and the per-object drawing/movement blocks, which consume visible, loadX, topLeftX and speed.

Parameters:
- NUM_OBJ, 4, number of object slots (1..8).
- X_BITS, 11, width of each topLeftX field (signed).
- SPEED_BITS, 8, width of objectSpeed and each speed field.
- MIN_X, 32, smallest launch X (inclusive).
- MAX_X, 576, largest launch X (inclusive); MAX_X >= MIN_X.
- CNT_BITS, 8, countdown width.
- MIN_WAIT, 50, minimum reappear delay in ticks; must be >= 1.
- MAX_WAIT, 150, maximum reappear delay in ticks; MAX_WAIT < 2^CNT_BITS.
- MAX_ACTIVE, 2, maximum slots in MOVING at once (1..NUM_OBJ).
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- startOfLevel  in  1  pulse; starts all IDLE slots.
- endLevel  in  1  level; forces all slots to IDLE.
- enable  in  1  0 = game paused.
- tick  in  1  one-cycle pulse every 0.1 s.
- exceed  in  NUM_OBJ  per-slot pulse; object left the screen.
- objectSpeed  in  SPEED_BITS  current level speed.
- visible  out  NUM_OBJ  slot is in MOVING.
- loadX  out  NUM_OBJ  slot is in WAIT or ARMED; downstream holds its position at topLeftX.
- topLeftX  out  NUM_OBJ*X_BITS  slot i occupies bits [i*X_BITS +: X_BITS]; signed.
- speed  out  NUM_OBJ*SPEED_BITS  slot i carries objectSpeed when MOVING, else 0.
- activeCount  out  4  number of slots currently in MOVING.

Behaviour:
- Reset (asynchronous on resetN low):
  - All slots go to IDLE.
  - All countdowns and all topLeftX fields are cleared to 0.
  - LFSR is loaded with SEED.
  - All outputs read 0.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every clk, independent of enable.
  - Slot value: r_i = lfsr XOR (i * 16'h9E37), computed in 16 bits.
- Random delay: MIN_WAIT + (r_i mod (MAX_WAIT-MIN_WAIT+1)).
- Random X: MIN_X + (r_i mod (MAX_X-MIN_X+1)), truncated to X_BITS.
- Per-slot states: IDLE, WAIT, ARMED, MOVING. All state is registered; outputs are decoded from state.
- IDLE:
  - startOfLevel -> WAIT, loading the countdown with the random delay.
- WAIT:
  - On tick with enable high, the countdown decrements.
  - A countdown of 1 decremented by tick -> ARMED.
  - With enable low, the countdown holds its value.
- ARMED:
  - Waits for a launch grant.
  - Grant rule: enable=1 and activeCount < MAX_ACTIVE; only the lowest-index ARMED slot is granted.
  - At most one launch per cycle.
  - On grant: topLeftX_i <= random X, state -> MOVING, visible_i rises on the next cycle.
- MOVING:
  - visible_i = 1 and speed_i = objectSpeed; speed follows objectSpeed combinationally.
  - exceed_i = 1 or enable = 0 -> WAIT, reloading the countdown with a fresh random delay.
  - topLeftX_i holds its last value.
- activeCount is decoded from registered state, so a slot leaving MOVING in cycle t still counts in cycle t. A launch can therefore use the freed place no earlier than cycle t+1.
- Priorities within a slot, highest first: reset > endLevel (-> IDLE from any state, countdown cleared, topLeftX held) > startOfLevel (IDLE only) > exceed/enable > tick.
- startOfLevel and endLevel in the same cycle: endLevel wins.
- exceed_i in a state other than MOVING: ignored.
- A countdown load and a tick in the same cycle: the load wins and no decrement is applied.
- Grant requests and the LFSR sample use current-cycle register values.
- Reset asserted mid-level returns everything to the reset values, with no wait for a level boundary.

Test Plan:
- Reset -> reset values: assert resetN=0 mid-MOVING -> visible=0, speed=0, topLeftX=0, activeCount=0 in the same cycle.
- Wait bounds: MIN_WAIT=MAX_WAIT=3, pulse startOfLevel, tick every 10 cycles -> every slot reaches ARMED exactly after the 3rd tick. Slot 0 becomes visible on the following cycle, slot 1 one cycle later, slots 2/3 remain ARMED (MAX_ACTIVE=2), activeCount=2.
- Exceed and relaunch: with the previous setup, pulse exceed[0] -> slot 0 goes to WAIT (loadX[0]=1, visible[0]=0). Slot 2 launches one cycle after activeCount drops to 1; slot 3 stays ARMED.
- Pause: deassert enable while two slots are MOVING -> both go to WAIT, speed=0; ticks during the pause do not decrement any countdown. Reassert enable -> countdowns resume from their held values.
- End of level: endLevel with startOfLevel in the same cycle -> all slots IDLE, visible=0, and no launch follows until a later startOfLevel.
- Randomness range: run 10,000 launches with MIN_X=32, MAX_X=576 and default waits -> every sampled topLeftX is in [32,576] and every delay is in [50,150]. Both endpoints are hit at least once, and no two slots launched in the same level share an identical (X, delay) sequence.
